// File: rtl/e203_exu_rglr_wbck_buf.sv
// e203_exu_rglr_wbck_buf
// Two-entry buffer between the regular ALU and its two consumers: the integer
// regfile write-back port and the commit port. The head entry is offered to
// both ports independently. It leaves the buffer once each port that needs it
// has taken it. When a WFI commits, the buffer enters SLEEP. In SLEEP it
// accepts nothing and presents nothing until wfi_wakeup is seen.
// Every output is decoded from registered state only, so no input reaches an
// output combinationally.

module e203_exu_rglr_wbck_buf #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               rglr_i_valid,
  output logic               rglr_i_ready,
  input  logic [XLEN-1:0]    rglr_i_wdat,
  input  logic [4:0]         rglr_i_rdidx,
  input  logic               rglr_i_rdwen,
  input  logic [PC_SIZE-1:0] rglr_i_pc,
  input  logic               rglr_i_err,
  input  logic               rglr_i_ecall,
  input  logic               rglr_i_ebreak,
  input  logic               rglr_i_wfi,

  output logic               wbck_o_valid,
  input  logic               wbck_o_ready,
  output logic [XLEN-1:0]    wbck_o_wdat,
  output logic [4:0]         wbck_o_rdidx,

  output logic               cmt_o_valid,
  input  logic               cmt_o_ready,
  output logic [PC_SIZE-1:0] cmt_o_pc,
  output logic               cmt_o_ecall,
  output logic               cmt_o_ebreak,
  output logic               cmt_o_wfi,

  input  logic               wfi_wakeup,
  output logic               wfi_halted
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]    wdat;
    logic [4:0]         rdidx;
    logic               rdwen;
    logic [PC_SIZE-1:0] pc;
    logic               err;
    logic               ecall;
    logic               ebreak;
    logic               wfi;
  } entry_t;

  // An entry goes to the regfile only if it writes rd and did not trap.
  function automatic logic need_wbck_f(input entry_t e);
    return e.rdwen & ~e.err;
  endfunction

  // Storage and control state
  entry_t     fifo_r [0:1];
  logic       wptr_r;
  logic       rptr_r;
  logic [1:0] count_r;
  logic       wbck_done_r;
  logic       cmt_done_r;
  state_t     state_r;

  // Combinational control
  entry_t     in_entry_s;
  entry_t     head_s;
  entry_t     head_vis_s;
  logic       empty_s;
  logic       full_s;
  logic       gate_s;
  logic       need_wbck_s;
  logic       enq_s;
  logic       pop_s;
  logic       wbck_fire_s;
  logic       cmt_fire_s;
  logic       wbck_ok_s;
  logic       cmt_ok_s;
  logic [1:0] count_nxt_s;

  assign in_entry_s = '{
    wdat:   rglr_i_wdat,
    rdidx:  rglr_i_rdidx,
    rdwen:  rglr_i_rdwen,
    pc:     rglr_i_pc,
    err:    rglr_i_err,
    ecall:  rglr_i_ecall,
    ebreak: rglr_i_ebreak,
    wfi:    rglr_i_wfi
  };

  assign head_s      = fifo_r[rptr_r];
  assign empty_s     = (count_r == 2'd0);
  assign full_s      = (count_r == 2'd2);
  assign gate_s      = (state_r == ST_SLEEP);
  assign need_wbck_s = need_wbck_f(head_s);

  // No pass-through: ready depends only on registered state. A pop in the
  // same cycle therefore cannot open a slot for a new entry.
  assign rglr_i_ready = ~full_s & (state_r == ST_RUN);
  assign enq_s        = rglr_i_valid & rglr_i_ready;

  assign wbck_o_valid = ~empty_s & need_wbck_s & ~wbck_done_r & ~gate_s;
  assign cmt_o_valid  = ~empty_s & ~cmt_done_r & ~gate_s;
  assign wbck_fire_s  = wbck_o_valid & wbck_o_ready;
  assign cmt_fire_s   = cmt_o_valid & cmt_o_ready;

  // The head is finished once every port that needs it has taken it, either
  // in an earlier cycle or in this one.
  assign wbck_ok_s = ~need_wbck_s | wbck_done_r | wbck_fire_s;
  assign cmt_ok_s  = cmt_done_r | cmt_fire_s;
  assign pop_s     = ~empty_s & wbck_ok_s & cmt_ok_s;

  assign wfi_halted = gate_s;

  // Payloads show the head entry and read as zero when the buffer is empty.
  always_comb begin
    head_vis_s = '0;
    if (empty_s) begin
      head_vis_s = '0;
    end else begin
      head_vis_s = head_s;
    end
  end

  assign wbck_o_wdat  = head_vis_s.wdat;
  assign wbck_o_rdidx = head_vis_s.rdidx;
  assign cmt_o_pc     = head_vis_s.pc;
  assign cmt_o_ecall  = head_vis_s.ecall;
  assign cmt_o_ebreak = head_vis_s.ebreak;
  assign cmt_o_wfi    = head_vis_s.wfi;

  // Next occupancy: an enqueue and a pop in the same cycle cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({enq_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry storage: write the incoming result into the slot at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_r[i] <= '0;
      end
    end else if (enq_s) begin
      fifo_r[wptr_r] <= in_entry_s;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq_s) begin
        wptr_r <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

  // Per-head done flags: remember a port that already took the head.
  // A pop clears both flags for the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbck_done_r <= 1'b0;
      cmt_done_r  <= 1'b0;
    end else if (pop_s) begin
      wbck_done_r <= 1'b0;
      cmt_done_r  <= 1'b0;
    end else begin
      if (wbck_fire_s) begin
        wbck_done_r <= 1'b1;
      end
      if (cmt_fire_s) begin
        cmt_done_r <= 1'b1;
      end
    end
  end

  // WFI sleep FSM: sleep after a WFI commits, wake on wfi_wakeup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (cmt_fire_s & head_s.wfi) begin
            state_r <= ST_SLEEP;
          end
        end
        ST_SLEEP: begin
          if (wfi_wakeup) begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_e203_exu_rglr_wbck_buf.sv
// Directed, table-driven bench for e203_exu_rglr_wbck_buf.
// Each table row holds the inputs for one cycle and the outputs expected
// during that cycle, before the next rising edge. A hand-written sequence
// then applies an asynchronous reset while the buffer is asleep and holds
// two entries.

module tb_e203_exu_rglr_wbck_buf;

  typedef struct packed {
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        rdwen;
    logic [31:0] pc;
    logic        err;
    logic [2:0]  flg;   // {ecall, ebreak, wfi}
  } ent_t;

  typedef struct packed {
    logic vin;
    ent_t ent;
    logic wrdy;
    logic crdy;
    logic wake;
    logic e_rdy;
    logic e_wv;
    logic e_cv;
    logic e_halt;
    ent_t head;
  } vec_t;

  localparam ent_t NONE = '{32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 3'b000};
  localparam ent_t ADD1 = '{32'h0000_00FF, 5'd5, 1'b1, 32'h0000_0100, 1'b0, 3'b000};
  localparam ent_t E1   = '{32'h0000_0011, 5'd1, 1'b1, 32'h0000_0200, 1'b0, 3'b000};
  localparam ent_t E2   = '{32'h0000_0022, 5'd2, 1'b1, 32'h0000_0204, 1'b0, 3'b000};
  localparam ent_t E3   = '{32'h0000_0033, 5'd3, 1'b1, 32'h0000_0208, 1'b0, 3'b000};
  localparam ent_t EC   = '{32'h0000_DEAD, 5'd7, 1'b1, 32'h8000_0010, 1'b1, 3'b100};
  localparam ent_t WF   = '{32'h0000_0000, 5'd0, 1'b0, 32'h0000_0300, 1'b0, 3'b001};
  localparam ent_t AD   = '{32'h0000_0044, 5'd4, 1'b1, 32'h0000_0304, 1'b0, 3'b000};
  localparam ent_t F1   = '{32'h0000_0051, 5'd11, 1'b1, 32'h0000_0400, 1'b0, 3'b000};
  localparam ent_t F2   = '{32'h0000_0052, 5'd12, 1'b1, 32'h0000_0404, 1'b0, 3'b000};
  localparam ent_t F3   = '{32'h0000_0053, 5'd13, 1'b1, 32'h0000_0408, 1'b0, 3'b000};
  localparam ent_t G    = '{32'h0000_0061, 5'd21, 1'b1, 32'h0000_0500, 1'b0, 3'b010};
  localparam ent_t W2   = '{32'h0000_0099, 5'd9, 1'b1, 32'h0000_0600, 1'b0, 3'b001};
  localparam ent_t B    = '{32'h0000_0077, 5'd10, 1'b1, 32'h0000_0604, 1'b0, 3'b000};

  logic        clk;
  logic        rst_n;
  logic        rglr_i_valid;
  logic        rglr_i_ready;
  logic [31:0] rglr_i_wdat;
  logic [4:0]  rglr_i_rdidx;
  logic        rglr_i_rdwen;
  logic [31:0] rglr_i_pc;
  logic        rglr_i_err;
  logic        rglr_i_ecall;
  logic        rglr_i_ebreak;
  logic        rglr_i_wfi;
  logic        wbck_o_valid;
  logic        wbck_o_ready;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx;
  logic        cmt_o_valid;
  logic        cmt_o_ready;
  logic [31:0] cmt_o_pc;
  logic        cmt_o_ecall;
  logic        cmt_o_ebreak;
  logic        cmt_o_wfi;
  logic        wfi_wakeup;
  logic        wfi_halted;

  int   total;
  int   bad;
  vec_t vq[$];

  e203_exu_rglr_wbck_buf #(.XLEN(32), .PC_SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rglr_i_valid (rglr_i_valid),
    .rglr_i_ready (rglr_i_ready),
    .rglr_i_wdat  (rglr_i_wdat),
    .rglr_i_rdidx (rglr_i_rdidx),
    .rglr_i_rdwen (rglr_i_rdwen),
    .rglr_i_pc    (rglr_i_pc),
    .rglr_i_err   (rglr_i_err),
    .rglr_i_ecall (rglr_i_ecall),
    .rglr_i_ebreak(rglr_i_ebreak),
    .rglr_i_wfi   (rglr_i_wfi),
    .wbck_o_valid (wbck_o_valid),
    .wbck_o_ready (wbck_o_ready),
    .wbck_o_wdat  (wbck_o_wdat),
    .wbck_o_rdidx (wbck_o_rdidx),
    .cmt_o_valid  (cmt_o_valid),
    .cmt_o_ready  (cmt_o_ready),
    .cmt_o_pc     (cmt_o_pc),
    .cmt_o_ecall  (cmt_o_ecall),
    .cmt_o_ebreak (cmt_o_ebreak),
    .cmt_o_wfi    (cmt_o_wfi),
    .wfi_wakeup   (wfi_wakeup),
    .wfi_halted   (wfi_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic er, input logic ewv, input logic ecv,
                          input logic eh, input ent_t hd);
    chk("ready",  idx, 64'(rglr_i_ready), 64'(er));
    chk("wvalid", idx, 64'(wbck_o_valid), 64'(ewv));
    chk("cvalid", idx, 64'(cmt_o_valid),  64'(ecv));
    chk("halted", idx, 64'(wfi_halted),   64'(eh));
    chk("wdat",   idx, 64'(wbck_o_wdat),  64'(hd.wdat));
    chk("rdidx",  idx, 64'(wbck_o_rdidx), 64'(hd.rdidx));
    chk("pc",     idx, 64'(cmt_o_pc),     64'(hd.pc));
    chk("flags",  idx, 64'({cmt_o_ecall, cmt_o_ebreak, cmt_o_wfi}), 64'(hd.flg));
  endtask

  task automatic drive(input logic vin, input ent_t e, input logic wr, input logic cr, input logic wk);
    rglr_i_valid  = vin;
    rglr_i_wdat   = e.wdat;
    rglr_i_rdidx  = e.rdidx;
    rglr_i_rdwen  = e.rdwen;
    rglr_i_pc     = e.pc;
    rglr_i_err    = e.err;
    rglr_i_ecall  = e.flg[2];
    rglr_i_ebreak = e.flg[1];
    rglr_i_wfi    = e.flg[0];
    wbck_o_ready  = wr;
    cmt_o_ready   = cr;
    wfi_wakeup    = wk;
  endtask

  task automatic add(input logic vin, input ent_t e, input logic wr, input logic cr, input logic wk,
                     input logic er, input logic ewv, input logic ecv, input logic eh, input ent_t hd);
    vec_t v;
    v.vin = vin; v.ent = e; v.wrdy = wr; v.crdy = cr; v.wake = wk;
    v.e_rdy = er; v.e_wv = ewv; v.e_cv = ecv; v.e_halt = eh; v.head = hd;
    vq.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Single ADD with both consumers ready
    add(1'b1, ADD1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, ADD1);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // Three back-to-back entries, write-back stalled for four cycles
    add(1'b1, E1,   1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b1, E2,   1'b0, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, E1);
    add(1'b1, E3,   1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, E1);
    add(1'b1, E3,   1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, E1);
    add(1'b1, E3,   1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, E1);
    add(1'b1, E3,   1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, E2);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, E3);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // ecall with err: never written back, commit held then taken
    add(1'b1, EC,   1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b0, NONE, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, EC);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, EC);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // WFI then ADD: sleep, single-cycle wakeup, wakeup ignored in RUN
    add(1'b1, WF,   1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b1, AD,   1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, WF);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, AD);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, AD);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, AD);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, AD);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // Full buffer: pop with valid input does not accept, next cycle does
    add(1'b1, F1,   1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b1, F2,   1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, F1);
    add(1'b1, F3,   1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, F1);
    add(1'b1, F3,   1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, F2);
    add(1'b0, NONE, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, F2);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, F2);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, F3);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // Write-back taken before commit: wbck valid drops, commit pops later
    add(1'b1, G,    1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);
    add(1'b0, NONE, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, G);
    add(1'b0, NONE, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, G);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, G);
    add(1'b0, NONE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, NONE);

    // Reset and its output values
    drive(1'b0, NONE, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_outs(1000, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    rst_n = 1'b1;

    // Table-driven part
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].vin, vq[i].ent, vq[i].wrdy, vq[i].crdy, vq[i].wake);
      #1;
      chk_outs(i, vq[i].e_rdy, vq[i].e_wv, vq[i].e_cv, vq[i].e_halt, vq[i].head);
    end

    // Asleep with two entries (WFI still waiting for write-back), then async reset
    @(negedge clk);
    drive(1'b1, W2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, B, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, NONE, 1'b0, 1'b1, 1'b0);
    #1;
    chk_outs(2000, 1'b0, 1'b1, 1'b1, 1'b0, W2);
    @(negedge clk);
    drive(1'b0, NONE, 1'b0, 1'b0, 1'b0);
    #1;
    chk_outs(2001, 1'b0, 1'b0, 1'b0, 1'b1, W2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs(2002, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs(2003, 1'b1, 1'b0, 1'b0, 1'b0, NONE);

    // Normal operation resumes after reset
    drive(1'b1, ADD1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, NONE, 1'b1, 1'b1, 1'b0);
    #1;
    chk_outs(2004, 1'b1, 1'b1, 1'b1, 1'b0, ADD1);
    @(negedge clk);
    #1;
    chk_outs(2005, 1'b1, 1'b0, 1'b0, 1'b0, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
